// File: rtl/fc_serializer.sv
// ---------------------------------------------------------------------------
// fc_serializer
//
// Purpose:
//   Takes one fully-connected layer output vector (LAYER_HEIGHT signed words)
//   in a single valid/ready handshake and hands it to a downstream consumer
//   one word at a time. The consumer reads words with ren_i. An optional
//   ReLU is applied to the words as they are captured.
//
//   A small two-state FSM controls the block. In eIDLE the buffer is empty.
//   In eSEND the buffer holds a vector that is being read out. While the
//   last word is being read, a new vector can be accepted in the same cycle,
//   so vectors can stream back to back with no gap.
//
// Parameters:
//   WORD_SIZE     word width in bits (signed two's complement)
//   LAYER_HEIGHT  words per input vector (2 or more)
//   RELU          1: negative words are stored as zero, 0: words pass as-is
//
// Ports:
//   clk_i      sole clock, rising edge
//   reset_n_i  synchronous active-low reset
//   valid_i    upstream vector valid
//   ready_o    block can accept a vector this cycle
//   data_i     upstream vector, element k is neuron k
//   data_o     current serialized word (zero when empty)
//   empty_o    no word available for reading
//   ren_i      downstream read request
//   last_o     data_o holds element LAYER_HEIGHT-1
// ---------------------------------------------------------------------------
module fc_serializer #(
    parameter int WORD_SIZE    = 16,
    parameter int LAYER_HEIGHT = 2,
    parameter int RELU         = 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i,
    output logic [WORD_SIZE-1:0]                   data_o,
    output logic                                   empty_o,
    input  logic                                   ren_i,
    output logic                                   last_o
);

    localparam int               IDX_W    = $clog2(LAYER_HEIGHT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER_HEIGHT - 1);

    typedef enum logic {
        eIDLE = 1'b0,
        eSEND = 1'b1
    } state_t;

    state_t                                 state_q;
    state_t                                 state_d;
    logic [IDX_W-1:0]                       idx_q;
    logic [IDX_W-1:0]                       idx_d;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] buffer_q;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] buffer_d;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] captured;

    logic at_last;
    logic rd_fire;
    logic load_fire;

    // Words as they will be stored. With ReLU enabled a set sign bit forces
    // the stored word to zero; there is no width change and no saturation.
    always_comb begin
        captured = data_i;
        for (int k = 0; k < LAYER_HEIGHT; k++) begin
            if ((RELU != 0) && data_i[k][WORD_SIZE-1]) begin
                captured[k] = '0;
            end
        end
    end

    // Handshake qualifiers and outputs. ready_o in eSEND depends
    // combinationally on ren_i so a new vector can be taken in the same cycle
    // the last word is consumed.
    always_comb begin
        at_last   = (state_q == eSEND) && (idx_q == LAST_IDX);
        empty_o   = (state_q == eIDLE);
        last_o    = at_last;
        ready_o   = (state_q == eIDLE) || (at_last && ren_i);
        rd_fire   = ren_i && (state_q == eSEND);
        load_fire = valid_i && ready_o;
        data_o    = '0;
        if (state_q == eSEND) begin
            data_o = buffer_q[idx_q];
        end
    end

    // Next-state logic. A load always wins: it covers both the idle case and
    // the read-of-last-word case, and in both the index restarts at 0.
    // The buffer is only ever written on a load, so data_i changes while a
    // vector is being sent are invisible.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        buffer_d = buffer_q;
        if (load_fire) begin
            state_d  = eSEND;
            idx_d    = '0;
            buffer_d = captured;
        end else if (rd_fire) begin
            if (idx_q == LAST_IDX) begin
                state_d = eIDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // State registers with synchronous reset; reset also clears the buffer so
    // no stale word can ever reach data_o.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= eIDLE;
            idx_q    <= '0;
            buffer_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buffer_q <= buffer_d;
        end
    end

endmodule

// File: tb/tb_fc_serializer.sv
// ---------------------------------------------------------------------------
// tb_fc_serializer
//
// Purpose:
//   Self-checking bench for fc_serializer. Two instances (RELU=0 and RELU=1,
//   both LAYER_HEIGHT=4, WORD_SIZE=16) share the same stimulus. A table of
//   vectors holds each input and its expected post-ReLU words; on every
//   handshake the expected words are pushed to a per-instance queue and they
//   are popped as the consumer reads. A small control model predicts
//   empty_o, ready_o and last_o every cycle.
// ---------------------------------------------------------------------------
module tb_fc_serializer;

    localparam int WS = 16;
    localparam int LH = 4;

    typedef logic [LH-1:0][WS-1:0] vec_t;

    typedef struct {
        vec_t vec;
        vec_t relu;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          valid;
    logic          ren;
    vec_t          data_in;

    logic          ready0, empty0, last0;
    logic          ready1, empty1, last1;
    logic [WS-1:0] data0, data1;

    entry_t        tbl [6];
    vec_t          cur_vec;
    vec_t          cur_relu;
    int            ren_mode = 0;
    int            ren_cyc  = 0;

    int            vectors     = 0;
    int            miscompares = 0;

    logic [WS-1:0] q0 [$];
    logic [WS-1:0] q1 [$];

    logic          m_busy = 1'b0;
    int            m_idx  = 0;

    always #5 clk = ~clk;

    fc_serializer #(.WORD_SIZE(WS), .LAYER_HEIGHT(LH), .RELU(0)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid), .ready_o(ready0),
        .data_i(data_in), .data_o(data0), .empty_o(empty0), .ren_i(ren),
        .last_o(last0)
    );

    fc_serializer #(.WORD_SIZE(WS), .LAYER_HEIGHT(LH), .RELU(1)) dut_relu (
        .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid), .ready_o(ready1),
        .data_i(data_in), .data_o(data1), .empty_o(empty1), .ren_i(ren),
        .last_o(last1)
    );

    function automatic vec_t mk(input logic [WS-1:0] w0, input logic [WS-1:0] w1,
                                input logic [WS-1:0] w2, input logic [WS-1:0] w3);
        vec_t v;
        v[0] = w0; v[1] = w1; v[2] = w2; v[3] = w3;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [WS-1:0] act,
                               input logic [WS-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Read-enable generator: 0 = always high, 1 = pattern 1,0,0 repeating,
    // 2 = held low.
    always @(posedge clk) begin
        #1;
        case (ren_mode)
            0:       ren = 1'b1;
            1:       ren = (ren_cyc % 3 == 0);
            default: ren = 1'b0;
        endcase
        ren_cyc++;
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic exp_last, exp_ready, rd, hs;
        if (!reset_n) begin
            m_busy = 1'b0;
            m_idx  = 0;
            q0.delete();
            q1.delete();
        end else begin
            exp_last  = m_busy && (m_idx == LH - 1);
            exp_ready = !m_busy || (exp_last && ren);
            checkOutput("empty0", {15'd0, empty0}, {15'd0, !m_busy});
            checkOutput("empty1", {15'd0, empty1}, {15'd0, !m_busy});
            checkOutput("ready0", {15'd0, ready0}, {15'd0, exp_ready});
            checkOutput("ready1", {15'd0, ready1}, {15'd0, exp_ready});
            checkOutput("last0",  {15'd0, last0},  {15'd0, exp_last});
            checkOutput("last1",  {15'd0, last1},  {15'd0, exp_last});
            if (!m_busy) begin
                checkOutput("idle_data0", data0, '0);
                checkOutput("idle_data1", data1, '0);
            end else if (q0.size() == 0 || q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL sb_underflow: got %0d/%0d queued words required >0",
                         q0.size(), q1.size());
            end else begin
                checkOutput("data0", data0, q0[0]);
                checkOutput("data1", data1, q1[0]);
            end
            rd = m_busy && ren;
            hs = valid && exp_ready;
            if (rd && q0.size() > 0) void'(q0.pop_front());
            if (rd && q1.size() > 0) void'(q1.pop_front());
            if (hs) begin
                for (int k = 0; k < LH; k++) begin
                    q0.push_back(cur_vec[k]);
                    q1.push_back(cur_relu[k]);
                end
                m_busy = 1'b1;
                m_idx  = 0;
            end else if (rd) begin
                if (exp_last) begin
                    m_busy = 1'b0;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present table entry i and hold it until accepted; keep leaves valid
    // high afterwards so the next call streams back to back.
    task automatic applyStimulus(input int i, input bit keep);
        bit done = 1'b0;
        valid    = 1'b1;
        data_in  = tbl[i].vec;
        cur_vec  = tbl[i].vec;
        cur_relu = tbl[i].relu;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (ready0) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL handshake_timeout: got ready=0 required ready=1 (entry %0d)", i);
        end
        step(1);
        if (!keep) valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (empty0) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got empty=0 required empty=1");
        end
        step(1);
    endtask

    initial begin
        tbl[0] = '{vec: mk(16'd1, 16'hFFFE, 16'd3, 16'hFFFC),
                   relu: mk(16'd1, 16'h0000, 16'd3, 16'h0000)};
        tbl[1] = '{vec: mk(16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001),
                   relu: mk(16'h0000, 16'h7FFF, 16'h0000, 16'h0001)};
        tbl[2] = '{vec: mk(16'h0010, 16'h8001, 16'h1234, 16'hFFFE),
                   relu: mk(16'h0010, 16'h0000, 16'h1234, 16'h0000)};
        tbl[3] = '{vec: mk(16'd5, 16'd6, 16'd7, 16'd8),
                   relu: mk(16'd5, 16'd6, 16'd7, 16'd8)};
        tbl[4] = '{vec: mk(16'd9, 16'd10, 16'd11, 16'd12),
                   relu: mk(16'd9, 16'd10, 16'd11, 16'd12)};
        tbl[5] = '{vec: mk(16'd7, 16'd7, 16'd7, 16'd7),
                   relu: mk(16'd7, 16'd7, 16'd7, 16'd7)};

        // Reset with active inputs that must be ignored.
        reset_n  = 1'b0;
        valid    = 1'b1;
        data_in  = mk(16'hAAAA, 16'h5555, 16'h1111, 16'h2222);
        cur_vec  = '0;
        cur_relu = '0;
        ren      = 1'b1;
        step(3);
        reset_n = 1'b0;
        valid   = 1'b0;
        step(1);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_empty", {15'd0, empty0}, 16'd1);
        checkOutput("rst_ready", {15'd0, ready0}, 16'd1);
        checkOutput("rst_last",  {15'd0, last0},  16'd0);
        checkOutput("rst_data",  data0, 16'd0);
        step(1);

        // Basic streaming and ReLU vectors with ren held high.
        ren_mode = 0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(i, 1'b0);
            waitDrain();
            step(1);
        end

        // Read pulses while empty, then stalled reads with backpressure.
        ren_mode = 1;
        step(6);
        ren_mode = 2;
        step(1);
        applyStimulus(2, 1'b0);
        valid   = 1'b1;
        data_in = mk(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
        step(3);
        valid   = 1'b0;
        ren_mode = 1;
        waitDrain();

        // Back-to-back vectors with valid and ren held high.
        ren_mode = 0;
        step(1);
        applyStimulus(3, 1'b1);
        applyStimulus(4, 1'b0);
        waitDrain();

        // Reset after two of four reads, then a fresh vector.
        applyStimulus(0, 1'b0);
        step(2);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_empty", {15'd0, empty0}, 16'd1);
        checkOutput("midrst_ready", {15'd0, ready0}, 16'd1);
        checkOutput("midrst_data",  data0, 16'd0);
        checkOutput("midrst_data1", data1, 16'd0);
        step(1);
        applyStimulus(5, 1'b0);
        waitDrain();
        step(3);

        checkOutput("sb_left0", 16'(q0.size()), 16'd0);
        checkOutput("sb_left1", 16'(q1.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fc_serializer.md
FC_SERIALIZER -- requirements
Module: fc_serializer

Interface
REQ-001 The module SHALL have parameter WORD_SIZE, default 16, meaning word width in bits, signed two's complement.
REQ-002 The module SHALL have parameter LAYER_HEIGHT, default 2, meaning words per input vector; legal range is 2 or more.
REQ-003 The module SHALL have parameter RELU, default 1, where 1 applies ReLU at capture and 0 passes words unchanged.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n_i  input  1  reset; synchronous, active-low.
REQ-006 valid_i  input  1  upstream vector valid.
REQ-007 ready_o  output  1  block can accept a vector.
REQ-008 data_i  input  [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]  upstream vector; element k is neuron k.
REQ-009 data_o  output  WORD_SIZE  current serialized word.
REQ-010 empty_o  output  1  high when no word is available.
REQ-011 ren_i  input  1  downstream read request; a read completes when ren_i is high and empty_o is low.
REQ-012 last_o  output  1  high while data_o holds element LAYER_HEIGHT-1.

Function
REQ-013 The FSM SHALL have exactly two states: eIDLE (buffer empty) and eSEND (buffer holds a vector).
REQ-014 In eIDLE, ready_o SHALL be 1; in eSEND, ready_o SHALL be (last_o && ren_i), which is a combinational path from ren_i.
REQ-015 An input handshake SHALL be the cycle with valid_i && ready_o; on it, all LAYER_HEIGHT words are registered into the buffer, the index is set to 0, and the next state is eSEND.
REQ-016 With RELU=1, each word with sign bit 1 SHALL be stored as 0 and all other words stored unchanged; there is no width change and no saturation.
REQ-017 empty_o SHALL equal (state == eIDLE); after a handshake, the first word is readable on the next cycle (1-cycle latency).
REQ-018 data_o SHALL equal buffer[index] combinationally while in eSEND, and SHALL be 0 in eIDLE.
REQ-019 On a read with index < LAYER_HEIGHT-1, the index SHALL increment by 1 and the state SHALL remain eSEND.
REQ-020 On a read with index == LAYER_HEIGHT-1 and no simultaneous input handshake, the index SHALL reset to 0 and the next state SHALL be eIDLE.
REQ-021 On a read of the last word in the same cycle as an input handshake, the new vector SHALL load, the index SHALL be 0, and the state SHALL remain eSEND, giving back-to-back vectors with no empty cycle.
REQ-022 ren_i while empty_o=1 SHALL be ignored, with no state or index change.
REQ-023 valid_i while ready_o=0 SHALL be ignored, and upstream holds data_i.
REQ-024 Buffered words SHALL not change except on an input handshake; a changing data_i has no effect during eSEND.
REQ-025 The index counter width SHALL be $clog2(LAYER_HEIGHT) bits and the index SHALL never exceed LAYER_HEIGHT-1.
REQ-026 Steady-state throughput SHALL be LAYER_HEIGHT words per LAYER_HEIGHT cycles when ren_i is held high and valid_i is held high.

Reset
REQ-027 While reset_n_i=0 at a clock edge, the state SHALL become eIDLE, the index 0, and the buffer all zeros.
REQ-028 The values after reset SHALL be ready_o=1, empty_o=1, data_o=0, last_o=0.
REQ-029 A reset asserted mid-vector SHALL discard the remaining words, and the first read after release SHALL come only from a newly handshaken vector.
REQ-030 Inputs SHALL be ignored during reset.

Verification
REQ-031 Basic: LAYER_HEIGHT=4, RELU=0, vector {1,-2,3,-4} handshaken, ren_i held high -> data_o 1,-2,3,-4 on 4 consecutive cycles; last_o only on -4; then empty_o=1.
REQ-032 ReLU: RELU=1, vector {0x8000,0x7FFF,0xFFFF,0x0001} -> reads 0,0x7FFF,0,0x0001.
REQ-033 Stall: ren_i toggled 1,0,0,1,... -> each word is held on data_o while ren_i=0, with no skip or repeat; ren_i pulses while empty_o=1 leave state unchanged.
REQ-034 Back-to-back: valid_i held high with two vectors {5,6,7,8} then {9,10,11,12}, ren_i high -> 8 reads on 8 consecutive cycles, ready_o high in the cycle of the 8 read, empty_o never high between vectors.
REQ-035 Backpressure: valid_i high during eSEND with last_o=0 -> ready_o=0, and data_i changes do not alter buffered words.
REQ-036 Reset mid-vector: reset_n_i=0 after 2 of 4 reads -> next cycle empty_o=1, ready_o=1, data_o=0, and a subsequent vector {7,7,7,7} reads out fully starting at index 0.
